cas_fsk_tx: RTL and testbench

Cassette FSK modulator for the MSX1 core: turns a stream of header/byte commands into the 1-bit MSX cassette waveform (1200/2400 baud FSK) that feeds the machine's `cas_audio_in`. It is the playback end of the tape path. A loader drives bytes from a CAS image into the block, the block emits the tape signal, and the BIOS reads it back through PSG port A bit 7 while `cas_motor` (PPI port C bit 4) gates progress.

---
 rtl/cas_fsk_tx_pkg.sv | 31 +++
 rtl/cas_fsk_tx_if.sv | 18 +
 rtl/cas_fsk_tx_bit_gen.sv | 58 +++++
 rtl/cas_fsk_tx.sv | 158 +++++++++++++++
 tb/tb_cas_fsk_tx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cas_fsk_tx_pkg.sv
// -----------------------------------------------------------------------------
// cas_pkg
// Shared definitions for the MSX cassette FSK modulator: frame state encoding,
// frame geometry, default timing constants and the FSK level lookup.
// No ports (package).
// -----------------------------------------------------------------------------
package cas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_START,
        ST_DATA,
        ST_STOP
    } cas_state_e;

    localparam int DATA_BITS              = 8;
    localparam int STOP_BITS              = 2;
    localparam int Q_TICKS_DEFAULT        = 746;   // ~1200 baud at 3.579545 MHz
    localparam int LONG_HDR_BITS_DEFAULT  = 8000;
    localparam int SHORT_HDR_BITS_DEFAULT = 2000;
    localparam int TICK_W                 = 12;    // quarter tick counter width
    localparam int HDR_W                  = 14;    // header bit counter width

    // A '1' bit toggles every quarter (1,0,1,0); a '0' bit toggles every
    // half bit (1,1,0,0). Both start high so bit boundaries never glitch.
    function automatic logic fsk_level(input logic bit_val, input logic [1:0] q);
        return bit_val ? ~q[0] : ~q[1];
    endfunction

endpackage

// File: rtl/cas_fsk_tx_if.sv
// -----------------------------------------------------------------------------
// cas_fsk_tx_if
// Command channel into the cassette modulator (valid/ready handshake).
//   in_valid  command present
//   in_hdr    1 = header command, 0 = data byte
//   in_data   byte to send; for a header, bit 0 selects long (1) / short (0)
//   in_ready  holding register empty
// master = loader side, slave = modulator side.
// -----------------------------------------------------------------------------
interface cas_fsk_tx_if;
    logic       in_valid;
    logic       in_hdr;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_hdr, output in_data, input in_ready);
    modport slave  (input in_valid, input in_hdr, input in_data, output in_ready);
endinterface

// File: rtl/cas_fsk_tx_bit_gen.sv
// -----------------------------------------------------------------------------
// cas_bit_gen
// Generates one FSK bit at a time: counts Q_TICKS qualifying ticks per quarter,
// steps the quarter index 0..3 and maps (bit, quarter) to the tape level.
//   clk, reset_n  clock / async active-low reset
//   tick          qualifying ce tick (ce & motor)
//   active        a frame is running (counters advance only then)
//   bit_val       value of the bit currently being sent
//   cas_audio     tape level, 0 while inactive
//   bit_done      pulse on the tick that ends quarter 3 of the current bit
// -----------------------------------------------------------------------------
import cas_pkg::*;

module cas_bit_gen #(
    parameter int Q_TICKS = Q_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic active,
    input  logic bit_val,
    output logic cas_audio,
    output logic bit_done
);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]        quarter_q, quarter_d;
    logic              wrap;

    assign wrap     = tick & active & (tick_cnt_q == TICK_W'(Q_TICKS - 1));
    assign bit_done = wrap & (quarter_q == 2'd3);

    // Counters naturally wrap back to 0 at the end of every bit, so a new
    // frame (or a return to idle) always starts from quarter 0, tick 0.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        quarter_d  = quarter_q;
        if (wrap) begin
            tick_cnt_d = '0;
            quarter_d  = quarter_q + 2'd1;
        end else if (tick & active) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            quarter_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            quarter_q  <= quarter_d;
        end
    end

    assign cas_audio = active & fsk_level(bit_val, quarter_q);

endmodule

// File: rtl/cas_fsk_tx.sv
// -----------------------------------------------------------------------------
// cas_fsk_tx
// MSX cassette FSK modulator. Turns header/byte commands into the 1-bit
// 1200/2400 baud tape waveform. Byte frame = start '0', 8 data bits LSB first,
// two stop '1' bits. Header = N '1' bits (long or short).
//   clk, reset_n  clock / async active-low reset
//   ce            3.58 MHz single-cycle clock enable
//   motor         1 = tape running, 0 = freeze generation
//   cmd           command channel (slave side)
//   cas_audio     FSK tape level
//   busy          frame running or command pending
// -----------------------------------------------------------------------------
import cas_pkg::*;

module cas_fsk_tx #(
    parameter int Q_TICKS        = Q_TICKS_DEFAULT,
    parameter int LONG_HDR_BITS  = LONG_HDR_BITS_DEFAULT,
    parameter int SHORT_HDR_BITS = SHORT_HDR_BITS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           motor,
    cas_fsk_tx_if.slave    cmd,
    output logic           cas_audio,
    output logic           busy
);

    localparam logic [HDR_W-1:0] LONG_LAST  = HDR_W'(LONG_HDR_BITS - 1);
    localparam logic [HDR_W-1:0] SHORT_LAST = HDR_W'(SHORT_HDR_BITS - 1);

    cas_state_e       state_q, state_d;
    logic             pend_q, pend_d;
    logic             pend_hdr_q, pend_hdr_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             long_q, long_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic [HDR_W-1:0] hdr_cnt_q, hdr_cnt_d;

    logic tick, active, accept, load, frame_end, bit_done, bit_val;
    logic [HDR_W-1:0] hdr_last;

    assign tick         = ce & motor;
    assign active       = (state_q != ST_IDLE);
    assign cmd.in_ready = ~pend_q;
    assign accept       = cmd.in_valid & ~pend_q;
    assign busy         = active | pend_q;
    assign hdr_last     = long_q ? LONG_LAST : SHORT_LAST;

    assign frame_end = bit_done &
                       (((state_q == ST_HDR)  && (hdr_cnt_q == hdr_last)) ||
                        ((state_q == ST_STOP) && (idx_q == 3'(STOP_BITS - 1))));

    // A pending command starts on the first qualifying tick from idle, or on
    // the very edge the previous frame ends so frames abut with no gap.
    assign load = tick & pend_q & (~active | frame_end);

    always_comb begin
        bit_val = 1'b0;
        case (state_q)
            ST_HDR:   bit_val = 1'b1;
            ST_START: bit_val = 1'b0;
            ST_DATA:  bit_val = shift_q[0];
            ST_STOP:  bit_val = 1'b1;
            default:  bit_val = 1'b0;
        endcase
    end

    // NOTE: every next-state signal takes its current value first, so no path
    // through the branches leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_hdr_d  = pend_hdr_q;
        pend_data_d = pend_data_q;
        long_d      = long_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        hdr_cnt_d   = hdr_cnt_q;

        if (accept) begin
            pend_d      = 1'b1;
            pend_hdr_d  = cmd.in_hdr;
            pend_data_d = cmd.in_data;
        end

        if (bit_done) begin
            case (state_q)
                ST_HDR:   hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                ST_START: begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
                ST_DATA:  begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_STOP:  idx_d = idx_q + 3'd1;
                default:  ;
            endcase
        end

        if (frame_end) state_d = ST_IDLE;

        // accept needs ~pend_q and load needs pend_q, so they never collide.
        if (load) begin
            pend_d    = 1'b0;
            state_d   = pend_hdr_q ? ST_HDR : ST_START;
            shift_d   = pend_data_q;
            long_d    = pend_data_q[0];
            idx_d     = '0;
            hdr_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the holding and shift registers are reset too, so a reset mid-frame
    // leaves nothing stale that a later load could pick up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            pend_hdr_q  <= 1'b0;
            pend_data_q <= '0;
            long_q      <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            hdr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_hdr_q  <= pend_hdr_d;
            pend_data_q <= pend_data_d;
            long_q      <= long_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            hdr_cnt_q   <= hdr_cnt_d;
        end
    end

    cas_bit_gen #(.Q_TICKS(Q_TICKS)) u_bit_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .active    (active),
        .bit_val   (bit_val),
        .cas_audio (cas_audio),
        .bit_done  (bit_done)
    );

endmodule

// File: tb/tb_cas_fsk_tx.sv
// -----------------------------------------------------------------------------
// tb_cas_fsk_tx
// Directed bench for cas_fsk_tx with Q_TICKS=2, short header 3 bits, long
// header 5 bits. Expected tape levels are queued per ce tick when a command is
// issued and popped on each falling edge while a frame streams.
// -----------------------------------------------------------------------------
module tb_cas_fsk_tx;

    localparam int Q = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;
    logic motor   = 1'b1;
    logic cas_audio;
    logic busy;

    cas_fsk_tx_if cmd_if ();

    cas_fsk_tx #(
        .Q_TICKS        (Q),
        .LONG_HDR_BITS  (5),
        .SHORT_HDR_BITS (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .motor     (motor),
        .cmd       (cmd_if.slave),
        .cas_audio (cas_audio),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    logic last_audio = 1'b0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One bit = four quarters, each held Q ticks. '1' -> 1010, '0' -> 1100.
    task automatic push_bit(input logic b);
        logic [0:3] pat;
        pat = b ? 4'b1010 : 4'b1100;
        for (int qi = 0; qi < 4; qi++)
            for (int t = 0; t < Q; t++)
                exp_q.push_back(pat[qi]);
    endtask

    task automatic push_byte(input logic [7:0] d);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(d[i]);
        push_bit(1'b1);
        push_bit(1'b1);
    endtask

    task automatic push_hdr(input int n);
        for (int i = 0; i < n; i++) push_bit(1'b1);
    endtask

    // Call right after a falling edge; returns 1 time unit after the accept edge.
    task automatic send(input logic hdr, input logic [7:0] d);
        check("accept_ready", cmd_if.in_ready, 1'b1);
        cmd_if.in_valid = 1'b1;
        cmd_if.in_hdr   = hdr;
        cmd_if.in_data  = d;
        @(posedge clk);
        #1;
        cmd_if.in_valid = 1'b0;
    endtask

    // Issue from idle, queue the expected frame, check the one pending cycle.
    task automatic start_frame(input logic hdr, input logic [7:0] d);
        send(hdr, d);
        if (hdr) push_hdr(d[0] ? 5 : 3);
        else     push_byte(d);
        @(negedge clk);
        check("pending_audio", cas_audio, 1'b0);
        check("pending_busy", busy, 1'b1);
        check("pending_ready", cmd_if.in_ready, 1'b0);
    endtask

    task automatic drain(input int n, input string tag);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(tag, cas_audio, e);
                check({tag, "_busy"}, busy, 1'b1);
                last_audio = e;
            end
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_audio"}, cas_audio, 1'b0);
            check({tag, "_busy"}, busy, 1'b0);
            check({tag, "_ready"}, cmd_if.in_ready, 1'b1);
        end
    endtask

    initial begin
        // Reset held with a command offered: nothing may be accepted.
        cmd_if.in_valid = 1'b1;
        cmd_if.in_hdr   = 1'b0;
        cmd_if.in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_audio", cas_audio, 1'b0);
        check("rst_ready", cmd_if.in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        cmd_if.in_valid = 1'b0;
        reset_n = 1'b1;
        idle_check(6, "post_reset");

        // Byte 0x00: start, eight '0's, two stop '1's, then idle.
        start_frame(1'b0, 8'h00);
        drain(88, "byte00");
        idle_check(3, "byte00_end");

        // Byte 0xA5: data 1,0,1,0,0,1,0,1 LSB first.
        start_frame(1'b0, 8'hA5);
        drain(88, "byteA5");
        idle_check(2, "byteA5_end");

        // Short header with 0x55 queued during it: no gap between frames.
        start_frame(1'b1, 8'h00);
        drain(4, "short_hdr");
        send(1'b0, 8'h55);
        check("queued_ready_low", cmd_if.in_ready, 1'b0);
        push_byte(8'h55);
        drain(19, "short_hdr");
        check("hdr_tail_ready_low", cmd_if.in_ready, 1'b0);
        check("hdr_tail_busy", busy, 1'b1);
        drain(1, "short_hdr_last");
        drain(1, "byte55_first");
        check("byte55_loaded_ready", cmd_if.in_ready, 1'b1);
        drain(87, "byte55");
        idle_check(2, "byte55_end");

        // Long header selected by in_data[0].
        start_frame(1'b1, 8'h01);
        drain(40, "long_hdr");
        idle_check(2, "long_hdr_end");

        // Motor gating mid-quarter: level and position freeze for 10 cycles.
        start_frame(1'b0, 8'h3C);
        drain(7, "motor_pre");
        motor = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("motor_freeze_audio", cas_audio, last_audio);
            check("motor_freeze_busy", busy, 1'b1);
        end
        motor = 1'b1;
        drain(81, "motor_post");
        idle_check(2, "motor_end");

        // Reset in the middle of DATA with a command pending.
        start_frame(1'b0, 8'hFF);
        drain(20, "abort_pre");
        send(1'b0, 8'h12);
        check("abort_pending_ready", cmd_if.in_ready, 1'b0);
        check("abort_level_high", cas_audio, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_audio", cas_audio, 1'b0);
        check("abort_ready", cmd_if.in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle_check(8, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
